// File: rtl/ladybird_gpio_irq_pkg.sv
// ladybird_gpio_irq_pkg
//   Shared types and constants for the GPIO interrupt controller:
//   - irq_state_e : controller state (IDLE, WAIT, SERVICE, DONE)
//   - OFF_*       : register offsets within the 16-byte register window
package ladybird_gpio_irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      SERVICE = 2'd2,
      DONE    = 2'd3
   } irq_state_e;

   localparam logic [3:0] OFF_ENABLE   = 4'h0;
   localparam logic [3:0] OFF_PENDING  = 4'h4;
   localparam logic [3:0] OFF_CLAIM    = 4'h8;
   localparam logic [3:0] OFF_COMPLETE = 4'hC;

endpackage

// File: rtl/ladybird_bus_interface.sv
// ladybird_bus_interface
//   Simple single-cycle register bus.
//   req   : transfer request (read when wstrb == 0, write otherwise)
//   addr  : local byte address
//   wstrb : byte write strobes
//   wdata : write data
//   gnt   : request accepted
//   rdgnt : read data valid (same cycle)
//   rdata : read data
interface ladybird_bus_interface #(
   parameter int ADDR_W = 8
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        wstrb;
   logic [31:0]       wdata;
   logic              gnt;
   logic              rdgnt;
   logic [31:0]       rdata;

   modport primary (
      output req, addr, wstrb, wdata,
      input  gnt, rdgnt, rdata
   );

   modport secondary (
      input  req, addr, wstrb, wdata,
      output gnt, rdgnt, rdata
   );
endinterface

// File: rtl/ladybird_irq_arbiter.sv
// ladybird_irq_arbiter
//   Combinational winner select over a candidate vector.  The search starts
//   at index 'start' and wraps; with start tied to 0 it is fixed priority
//   (lowest index wins).
//   cand  : candidate vector (pending & enable)
//   start : index where the search begins
//   valid : at least one candidate present
//   idx   : index of the winning candidate (0 when !valid)
module ladybird_irq_arbiter #(
   parameter int N_SRC = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_SRC-1:0] cand,
   input  logic [IDX_W-1:0] start,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   // One extra bit so start + i cannot overflow before the wrap.
   logic [IDX_W:0] pos;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         pos = {1'b0, start} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(N_SRC)) pos = pos - (IDX_W+1)'(N_SRC);
         if (!valid && cand[pos[IDX_W-1:0]]) begin
            valid = 1'b1;
            idx   = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ladybird_gpio_irq.sv
// ladybird_gpio_irq
//   Interrupt arbiter and claim/complete controller between the GPIO block
//   and the core's external-interrupt input.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   bus      : register port (ENABLE 0x0, PENDING 0x4, CLAIM 0x8, COMPLETE 0xC)
//   pending  : per-source pending flags from the GPIO block
//   complete : per-source one-cycle completion pulse to the GPIO block
//   irq      : interrupt request to the core
//   Build option LADYBIRD_GPIO_IRQ_RR_EN: round-robin arbitration instead of
//   fixed priority (lowest index wins).
module ladybird_gpio_irq
   import ladybird_gpio_irq_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int ID_W  = $clog2(N_SRC+1)
) (
   input  logic                     clk,
   input  logic                     rst,
   ladybird_bus_interface.secondary bus,
   input  logic [N_SRC-1:0]         pending,
   output logic [N_SRC-1:0]         complete,
   output logic                     irq
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   irq_state_e       state, state_nxt;
   logic [ID_W-1:0]  cur, cur_nxt;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] cand;
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [ID_W-1:0]  win_id;
   logic [IDX_W-1:0] cur_idx;
   logic [IDX_W-1:0] start_ptr;
   logic             rr_adv;

   logic       rd_act, wr_act, in_win;
   logic [3:0] off;
   logic       claim_rd, cmpl_wr, en_wr;

   // Bus decode: only the first 16 bytes hold registers, anything above reads 0.
   assign rd_act = bus.req & ~|bus.wstrb;
   assign wr_act = bus.req & |bus.wstrb;
   assign off    = bus.addr[3:0];
   assign in_win = ((bus.addr >> 4) == '0);

   assign bus.gnt   = 1'b1;
   assign bus.rdgnt = rd_act;

   assign claim_rd = rd_act & in_win & (off == OFF_CLAIM) & (state == WAIT);
   assign cmpl_wr  = wr_act & in_win & (off == OFF_COMPLETE);
   assign en_wr    = wr_act & in_win & (off == OFF_ENABLE);

   logic unused_wdata;
   assign unused_wdata = ^bus.wdata[31:N_SRC];

   always_ff @(posedge clk) begin
      if (rst)        enable <= '0;
      else if (en_wr) enable <= bus.wdata[N_SRC-1:0];
   end

   assign cand    = pending & enable;
   assign cur_idx = IDX_W'(cur - ID_W'(1));
   assign win_id  = ID_W'(win_idx) + ID_W'(1);

   ladybird_irq_arbiter #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_arb (
      .cand  (cand),
      .start (start_ptr),
      .valid (win_vld),
      .idx   (win_idx)
   );

`ifdef LADYBIRD_GPIO_IRQ_RR_EN
   logic [IDX_W-1:0] rr_ptr;

   // Pointer moves one past the source just granted, wrapping at N_SRC.
   always_ff @(posedge clk) begin
      if (rst) rr_ptr <= '0;
      else if (rr_adv)
         rr_ptr <= (win_idx == IDX_W'(N_SRC-1)) ? '0 : win_idx + IDX_W'(1);
   end
   assign start_ptr = rr_ptr;
`else
   logic unused_rr;
   assign unused_rr = rr_adv;
   assign start_ptr = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cur   <= '0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      irq       = 1'b0;
      complete  = '0;
      rr_adv    = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               cur_nxt   = win_id;
               state_nxt = WAIT;
               rr_adv    = 1'b1;
            end
         end
         WAIT: begin
            irq = 1'b1;
            // A claim in the same cycle the source drops still wins.
            if (claim_rd) begin
               state_nxt = SERVICE;
            end else if (!cand[cur_idx]) begin
               state_nxt = IDLE;
               cur_nxt   = '0;
            end
         end
         SERVICE: begin
            // Enable/pending changes are ignored here; only a matching ID ends service.
            if (cmpl_wr && (bus.wdata[ID_W-1:0] == cur)) state_nxt = DONE;
         end
         DONE: begin
            complete  = N_SRC'(1) << cur_idx;
            cur_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cur_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      bus.rdata = '0;
      if (rd_act && in_win) begin
         case (off)
            OFF_ENABLE:  bus.rdata = 32'(enable);
            OFF_PENDING: bus.rdata = 32'(pending);
            OFF_CLAIM:   if (state == WAIT) bus.rdata = 32'(cur);
            default:     bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ladybird_gpio_irq.sv
// tb_ladybird_gpio_irq
//   Self-checking bench for ladybird_gpio_irq.  Expected values are pushed to
//   a scoreboard queue as stimulus is driven and popped when the DUT outputs
//   are sampled on the falling clock edge.
module tb_ladybird_gpio_irq;

   localparam logic [7:0] A_ENABLE   = 8'h00;
   localparam logic [7:0] A_PENDING  = 8'h04;
   localparam logic [7:0] A_CLAIM    = 8'h08;
   localparam logic [7:0] A_COMPLETE = 8'h0C;
   localparam logic [7:0] A_OUTSIDE  = 8'h10;

   logic       clk;
   logic       rst;
   logic [7:0] pending;
   logic [7:0] complete;
   logic       irq;

   ladybird_bus_interface #(.ADDR_W(8)) bus_if ();

   ladybird_gpio_irq #(.N_SRC(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .pending  (pending),
      .complete (complete),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endfunction

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_empty: got 0x%0h, expected an entry", obs);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle with irq/complete checked mid-cycle.
   task automatic cyc(input string tag, input logic exp_irq, input logic [7:0] exp_cmp);
      sb_push({tag, ".irq"}, 32'(exp_irq));
      sb_push({tag, ".complete"}, 32'(exp_cmp));
      @(negedge clk);
      sb_pop(32'(irq));
      sb_pop(32'(complete));
      step();
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus_if.req   = 1'b1;
      bus_if.addr  = a;
      bus_if.wstrb = 4'h0;
      bus_if.wdata = 32'h0;
      sb_push({tag, ".rdata"}, exp);
      sb_push({tag, ".rdgnt"}, 32'h1);
      @(negedge clk);
      sb_pop(bus_if.rdata);
      sb_pop(32'(bus_if.rdgnt));
      step();
      bus_if.req = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d);
      bus_if.req   = 1'b1;
      bus_if.addr  = a;
      bus_if.wstrb = 4'hF;
      bus_if.wdata = d;
      sb_push({tag, ".rdgnt"}, 32'h0);
      sb_push({tag, ".gnt"}, 32'h1);
      @(negedge clk);
      sb_pop(32'(bus_if.rdgnt));
      sb_pop(32'(bus_if.gnt));
      step();
      bus_if.req   = 1'b0;
      bus_if.wstrb = 4'h0;
   endtask

   // Full interrupt round trip starting in an IDLE cycle with candidates
   // visible; the GPIO side drops the serviced bit two cycles after the write.
   task automatic do_service(input string tag, input int id, input logic [7:0] pend_after);
      cyc({tag, " idle"}, 1'b0, 8'h00);
      cyc({tag, " wait"}, 1'b1, 8'h00);
      rd({tag, " claim"}, A_CLAIM, 32'(id));
      cyc({tag, " svc"}, 1'b0, 8'h00);
      wr({tag, " cmpl_wr"}, A_COMPLETE, 32'(id));
      cyc({tag, " done"}, 1'b0, 8'(1 << (id - 1)));
      pending = pend_after;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      pending      = 8'h00;
      bus_if.req   = 1'b0;
      bus_if.addr  = 8'h00;
      bus_if.wstrb = 4'h0;
      bus_if.wdata = 32'h0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      cyc("reset", 1'b0, 8'h00);
      rd("reset enable", A_ENABLE, 32'h0);

      // Single source: ENABLE=0x05, pending=0x04 -> ID 3
      pending = 8'h04;
      wr("t1 enable", A_ENABLE, 32'h05);
      do_service("t1", 3, 8'h00);
      cyc("t1 no rearb", 1'b0, 8'h00);
      cyc("t1 quiet", 1'b0, 8'h00);

      // Two simultaneous sources, then arbitration order
      pulse_reset();
      wr("t2 enable", A_ENABLE, 32'hFF);
      rd("t2 enable rb", A_ENABLE, 32'hFF);
      pending = 8'h0A;
      do_service("t2 a", 2, 8'h08);
      do_service("t2 b", 4, 8'h03);
      // Source 0 re-fires after its completion so both stay pending.
      do_service("t2 c", 1, 8'h03);
`ifdef LADYBIRD_GPIO_IRQ_RR_EN
      do_service("t2 d", 2, 8'h01);
      do_service("t2 e", 1, 8'h00);
`else
      do_service("t2 d", 1, 8'h02);
      do_service("t2 e", 2, 8'h00);
`endif
      cyc("t2 quiet", 1'b0, 8'h00);

      // CLAIM in IDLE; mismatched COMPLETE while servicing ID 3
      rd("t3 idle claim", A_CLAIM, 32'h0);
      cyc("t3 still idle", 1'b0, 8'h00);
      pending = 8'h04;
      cyc("t3 idle", 1'b0, 8'h00);
      cyc("t3 wait", 1'b1, 8'h00);
      rd("t3 claim", A_CLAIM, 32'h3);
      wr("t3 bad cmpl", A_COMPLETE, 32'h5);
      cyc("t3 ignored", 1'b0, 8'h00);
      cyc("t3 ignored2", 1'b0, 8'h00);
      wr("t3 good cmpl", A_COMPLETE, 32'h3);
      cyc("t3 done", 1'b0, 8'h04);
      pending = 8'h00;
      cyc("t3 after", 1'b0, 8'h00);

      // Enable withdrawn while waiting for a claim of ID 2
      pending = 8'h02;
      cyc("t4 idle", 1'b0, 8'h00);
      cyc("t4 wait", 1'b1, 8'h00);
      wr("t4 disable", A_ENABLE, 32'h00);
      step();
      cyc("t4 irq drop", 1'b0, 8'h00);
      rd("t4 late claim", A_CLAIM, 32'h0);
      pending = 8'h00;

      // Reset during SERVICE
      wr("t5 enable", A_ENABLE, 32'hFF);
      pending = 8'h04;
      cyc("t5 idle", 1'b0, 8'h00);
      cyc("t5 wait", 1'b1, 8'h00);
      rd("t5 claim", A_CLAIM, 32'h3);
      pulse_reset();
      cyc("t5 post rst", 1'b0, 8'h00);
      rd("t5 enable", A_ENABLE, 32'h0);
      rd("t5 claim idle", A_CLAIM, 32'h0);
      wr("t5 stale cmpl", A_COMPLETE, 32'h3);
      cyc("t5 no pulse", 1'b0, 8'h00);
      cyc("t5 no pulse2", 1'b0, 8'h00);
      pending = 8'h00;

      // PENDING readback and out-of-window read
      pending = 8'h81;
      rd("t6 pending", A_PENDING, 32'h81);
      rd("t6 outside", A_OUTSIDE, 32'h0);
      wr("t6 ro write", A_PENDING, 32'hFF);
      rd("t6 pending2", A_PENDING, 32'h81);
      cyc("t6 no irq", 1'b0, 8'h00);

      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
